var_shift_ctrl: RTL and testbench

VAR_SHIFT_CTRL -- requirements
Module: var_shift_ctrl

---
 rtl/var_shift_ctrl.sv | 127 ++++++++++++
 tb/tb_var_shift_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/var_shift_ctrl.sv
// var_shift_ctrl: sequences an external single-step shifter through load,
// N one-bit shift cycles (N clamped to WIDTH), result capture and a
// valid/ready response handshake.
module var_shift_ctrl #(
    parameter int WIDTH = 32,
    parameter int SW    = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [SW-1:0]    cmd_shift,
    input  logic             cmd_dir,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             sh_load,
    output logic             sh_en,
    output logic             sh_dir,
    output logic [WIDTH-1:0] sh_in,
    input  logic [WIDTH-1:0] sh_q
);

    // Counter must hold the value WIDTH itself (full clamp).
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             dir_q,   dir_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] rsp_q,   rsp_d;
    logic [CW-1:0]    n_clamp;

    // Clamp the requested amount to WIDTH; anything larger yields zero anyway.
    always_comb begin
        if (32'(cmd_shift) >= 32'(WIDTH)) begin
            n_clamp = CW'(WIDTH);
        end else begin
            n_clamp = CW'(cmd_shift);
        end
    end

    // Next-state, datapath updates and per-state control outputs.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        rsp_d     = rsp_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        sh_load   = 1'b0;
        sh_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by clr so no command is ever offered during reset.
                cmd_ready = clr;
                if (cmd_valid && clr) begin
                    data_d  = cmd_data;
                    dir_d   = cmd_dir;
                    cnt_d   = n_clamp;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sh_load = 1'b1;
                state_d = (cnt_q != '0) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
                sh_en = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_d   = sh_q;
                state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            data_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    // Latched operand/direction stay put between accepts, so the shifter
    // sees stable sh_in/sh_dir for the whole operation.
    assign sh_in    = data_q;
    assign sh_dir   = dir_q;
    assign rsp_data = rsp_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_var_shift_ctrl.sv
// Self-checking bench for var_shift_ctrl with a single-step shifter model.
module tb_var_shift_ctrl;

    localparam int WIDTH = 32;
    localparam int SW    = 6;

    logic             clk = 1'b0;
    logic             clr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [SW-1:0]    cmd_shift;
    logic             cmd_dir;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic             sh_load;
    logic             sh_en;
    logic             sh_dir;
    logic [WIDTH-1:0] sh_in;
    logic [WIDTH-1:0] sh_q = '0;

    int total = 0;
    int bad   = 0;

    var_shift_ctrl #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_shift (cmd_shift),
        .cmd_dir   (cmd_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sh_load   (sh_load),
        .sh_en     (sh_en),
        .sh_dir    (sh_dir),
        .sh_in     (sh_in),
        .sh_q      (sh_q)
    );

    always #5 clk = ~clk;

    // Single-step shifter: load on sh_load, one bit per sh_en cycle.
    always @(posedge clk) begin
        if (sh_load)    sh_q <= sh_in;
        else if (sh_en) sh_q <= sh_dir ? (sh_q >> 1) : (sh_q << 1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Cycle monitor: load/enable exclusivity, sh_in/sh_dir stability, sh_en count.
    logic             mon_on = 1'b0;
    int               en_cnt = 0;
    logic             prev_busy = 1'b0;
    logic [WIDTH-1:0] prev_in = '0;
    logic             prev_dir = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (sh_load)    en_cnt = 0;
            else if (sh_en) en_cnt++;
            check("load_en_excl", 64'(sh_load & sh_en), 64'(0));
            if (prev_busy && busy) begin
                check("sh_in_hold", 64'(sh_in), 64'(prev_in));
                check("sh_dir_hold", 64'(sh_dir), 64'(prev_dir));
            end
            prev_busy = busy;
            prev_in   = sh_in;
            prev_dir  = sh_dir;
        end
    end

    task automatic scramble_cmd();
        cmd_valid = 1'($urandom);
        cmd_data  = $urandom;
        cmd_shift = SW'($urandom);
        cmd_dir   = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    64'(busy),      64'(0));
        check({tag, "_rvalid"},  64'(rsp_valid), 64'(0));
        check({tag, "_rdata"},   64'(rsp_data),  64'(0));
        check({tag, "_load"},    64'(sh_load),   64'(0));
        check({tag, "_en"},      64'(sh_en),     64'(0));
        check({tag, "_dir"},     64'(sh_dir),    64'(0));
        check({tag, "_in"},      64'(sh_in),     64'(0));
        check({tag, "_cready"},  64'(cmd_ready), 64'(0));
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready_wait"}, 64'(cmd_ready), 64'(1));
    endtask

    // One full transaction against the arithmetic reference.
    task automatic run_cmd(input logic [WIDTH-1:0] d, input int unsigned s,
                           input logic dir, input int unsigned stall, input string tag);
        int unsigned      n;
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] held;
        int               lat;
        n   = (s > 32'(WIDTH)) ? 32'(WIDTH) : s;
        exp = dir ? (d >> n) : (d << n);
        wait_ready(tag);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_shift = SW'(s);
        cmd_dir   = dir;
        @(negedge clk);
        lat = 1;
        scramble_cmd();
        while (!rsp_valid && lat < 100) begin
            check({tag, "_busy_ready"}, 64'(cmd_ready), 64'(0));
            check({tag, "_sh_dir"}, 64'(sh_dir), 64'(dir));
            @(negedge clk);
            lat++;
            scramble_cmd();
        end
        check({tag, "_latency"}, 64'(lat), 64'(3 + n));
        check({tag, "_data"}, 64'(rsp_data), 64'(exp));
        check({tag, "_en_cycles"}, 64'(en_cnt), 64'(n));
        held = rsp_data;
        repeat (stall) begin
            @(negedge clk);
            scramble_cmd();
            check({tag, "_stall_valid"}, 64'(rsp_valid), 64'(1));
            check({tag, "_stall_data"}, 64'(rsp_data), 64'(held));
            check({tag, "_stall_ready"}, 64'(cmd_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        #1 check({tag, "_hs_cready"}, 64'(cmd_ready), 64'(0));
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check({tag, "_post_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_post_ready"}, 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        logic seen_rsp;
        clr       = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_shift = '0;
        cmd_dir   = 1'b0;
        rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        clr = 1'b1;
        #1 check("rst_release_ready", 64'(cmd_ready), 64'(1));
        mon_on = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_cmd(32'h7105C1A6, 11, 1'b0, 0, "left11");
        run_cmd(32'h7105C1A6, 11, 1'b1, 2, "right11");
        run_cmd(32'h7105C1A6, 0,  1'b0, 0, "zero_l");
        run_cmd(32'h7105C1A6, 0,  1'b1, 1, "zero_r");
        run_cmd(32'h7105C1A6, 40, 1'b0, 0, "clamp_l");
        run_cmd(32'h7105C1A6, 40, 1'b1, 0, "clamp_r");
        run_cmd(32'h80000001, 32, 1'b1, 0, "exact32");
        run_cmd(32'hFFFFFFFF, 31, 1'b0, 0, "s31");
        run_cmd(32'hDEADBEEF, 63, 1'b0, 0, "s63");
        run_cmd(32'h7105C1A6, 5,  1'b0, 5, "bp5");

        // Abort mid-SHIFT with a one-cycle clear.
        wait_ready("abort");
        cmd_valid = 1'b1;
        cmd_data  = $urandom;
        cmd_shift = SW'(20);
        cmd_dir   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_in_shift", 64'(sh_en), 64'(1));
        clr = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        clr = 1'b1;
        #1 check("abort_release_ready", 64'(cmd_ready), 64'(1));
        seen_rsp = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        check("abort_no_rsp", 64'(seen_rsp), 64'(0));
        run_cmd(32'h7105C1A6, 11, 1'b1, 0, "after_abort");

        // Randomized commands.
        for (int i = 0; i < 24; i++) begin
            run_cmd($urandom, $urandom_range(0, 63), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
